mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16: address and word width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive D grants tolerated while I waits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_read  input  1  instruction-fetch request; held high until i_done.
REQ-006 i_addr  input  WORD_SIZE  fetch word address; stable while i_read high.
REQ-007 i_rdata  output  WORD_SIZE  fetched word; valid in the i_done cycle.
REQ-008 i_done  output  1  one-cycle completion pulse for the I side.
REQ-009 d_read / d_write  input  1 each  data-cache line read / write request; held until d_done.
REQ-010 d_addr  input  WORD_SIZE  line-aligned data address; stable while requesting.
REQ-011 d_wdata  input  4*WORD_SIZE  write line; word 0 in bits [WORD_SIZE-1:0].
REQ-012 d_rdata  output  4*WORD_SIZE  read line; valid in the d_done cycle.
REQ-013 d_done  output  1  one-cycle completion pulse for the D side.
REQ-014 m_read / m_write  output  1 each  unified memory-port commands; mutually exclusive.
REQ-015 m_addr  output  WORD_SIZE  memory line address.
REQ-016 m_wdata  output  4*WORD_SIZE  memory write line.
REQ-017 m_rdata  input  4*WORD_SIZE  memory read line; valid when m_done high.
REQ-018 m_done  input  1  one-cycle memory completion pulse.
REQ-019 owner  output  2  current grant: 00 none, 01 I, 10 D.

Function
REQ-020 FSM states IDLE, I_BUSY, D_BUSY; only IDLE arbitrates.
REQ-021 IDLE: request sampled at edge t -> BUSY state and m_read/m_write asserted from cycle t+1.
REQ-022 Arbitration: D wins simultaneous requests unless starvation count equals STARVE_LIMIT, then I wins.
REQ-023 On grant, address/command/write data are latched; m_* driven from latched registers only.
REQ-024 I grant: m_read=1, m_addr = i_addr with bits [1:0] cleared.
REQ-025 i_rdata = word i_addr_latched[1:0] of m_rdata (word 0 = bits [WORD_SIZE-1:0]).
REQ-026 D grant: d_write high -> m_write=1 with d_wdata; else m_read=1; d_addr passed unchanged.
REQ-027 d_read and d_write both high: treated as write.
REQ-028 m_done in X_BUSY -> X_done high same cycle (combinational), m_read/m_write low next cycle, next state IDLE.
REQ-029 Mandatory one IDLE cycle between transactions; no back-to-back grant on the done cycle.
REQ-030 m_done while IDLE is ignored; no done pulse generated.
REQ-031 Command held asserted indefinitely until m_done; no timeout.
REQ-032 Outside the done cycle, i_rdata and d_rdata are don't-care.

Reset
REQ-033 reset: state IDLE, owner 00, m_read=m_write=0, i_done=d_done=0, latches and starvation count 0.
REQ-034 reset mid-transaction aborts it with no done pulse; requester reissues.

Configuration
REQ-035 Macro MEM_ARB_STARVE_GUARD_EN defined: starvation counter present, REQ-022 applies.
REQ-036 Undefined: strict D priority; I granted only when no D request in IDLE; counter logic absent.
REQ-037 Starvation count: +1 per D grant made while i_read high; cleared on I grant or when i_read low in IDLE; saturates at STARVE_LIMIT.

Structure
REQ-038 Package mem_arb_pkg holds state enum, owner encodings (OWN_NONE/OWN_I/OWN_D), STARVE_LIMIT default.
REQ-039 Sub-module mem_arb_starve_cnt holds the counter, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-040 I-only: i_read, i_addr=0x0013, memory returns line 0xDDDD_CCCC_BBBB_AAAA after 3 cycles -> m_addr=0x0010, i_rdata=0xDDDD, i_done 1 cycle.
REQ-041 Simultaneous i_read+d_write at IDLE -> D granted first (owner 10, m_write=1), I granted after one IDLE cycle.
REQ-042 Guard on, STARVE_LIMIT=4, i_read held, d_read reasserted every transaction -> 4 D grants, then I granted; guard off -> I never granted while D requests.
REQ-043 reset asserted in D_BUSY before m_done -> next cycle IDLE, m_write=0, no d_done even if m_done arrives.
REQ-044 d_read+d_write both high, d_addr=0x0040 -> m_write=1, m_read=0, m_addr=0x0040; stray m_done in IDLE -> no done pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int LINE_WORDS       = 4;

    // Bits needed to hold a count that saturates at limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of D grants issued while the I side is waiting.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic limit_o
);

    localparam int CW = cnt_width(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign limit_o = (cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-fetch and D-cache requests onto one memory port.
// Define MEM_ARB_STARVE_GUARD_EN to let a waiting I side win after STARVE_LIMIT D grants.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_read,
    input  logic [WORD_SIZE-1:0]            i_addr,
    output logic [WORD_SIZE-1:0]            i_rdata,
    output logic                            i_done,
    input  logic                            d_read,
    input  logic                            d_write,
    input  logic [WORD_SIZE-1:0]            d_addr,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] d_wdata,
    output logic [LINE_WORDS*WORD_SIZE-1:0] d_rdata,
    output logic                            d_done,
    output logic                            m_read,
    output logic                            m_write,
    output logic [WORD_SIZE-1:0]            m_addr,
    output logic [LINE_WORDS*WORD_SIZE-1:0] m_wdata,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] m_rdata,
    input  logic                            m_done,
    output logic [1:0]                      owner
);

    state_e                            state_q;
    logic [1:0]                        owner_q;
    logic                              m_read_q;
    logic                              m_write_q;
    logic [WORD_SIZE-1:0]              m_addr_q;
    logic [LINE_WORDS*WORD_SIZE-1:0]   m_wdata_q;
    logic [1:0]                        word_sel_q;

    logic arb_idle;
    logic d_req;
    logic starve_hit;
    logic grant_i;
    logic grant_d;

    assign arb_idle = (state_q == IDLE);
    assign d_req    = d_read | d_write;
    assign grant_i  = arb_idle && i_read && (!d_req || starve_hit);
    assign grant_d  = arb_idle && d_req && !grant_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (grant_d && i_read),
        .clr_i   (arb_idle && (grant_i || !i_read)),
        .limit_o (starve_hit)
    );
`else
    localparam int unused_starve_limit = STARVE_LIMIT;
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: latched address/data are small registers, so they are cleared along with the FSM.
            state_q    <= IDLE;
            owner_q    <= OWN_NONE;
            m_read_q   <= 1'b0;
            m_write_q  <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            word_sel_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= D_BUSY;
                        owner_q   <= OWN_D;
                        m_write_q <= d_write;
                        m_read_q  <= !d_write;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                    end else if (grant_i) begin
                        state_q    <= I_BUSY;
                        owner_q    <= OWN_I;
                        m_read_q   <= 1'b1;
                        m_write_q  <= 1'b0;
                        m_addr_q   <= {i_addr[WORD_SIZE-1:2], 2'b00};
                        word_sel_q <= i_addr[1:0];
                    end
                end
                I_BUSY, D_BUSY: begin
                    // Completion always returns to IDLE so no grant lands on the done cycle.
                    if (m_done) begin
                        state_q   <= IDLE;
                        owner_q   <= OWN_NONE;
                        m_read_q  <= 1'b0;
                        m_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    owner_q   <= OWN_NONE;
                    m_read_q  <= 1'b0;
                    m_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign i_done  = (state_q == I_BUSY) && m_done;
    assign d_done  = (state_q == D_BUSY) && m_done;
    assign i_rdata = m_rdata[word_sel_q*WORD_SIZE +: WORD_SIZE];
    assign d_rdata = m_rdata;
    assign m_read  = m_read_q;
    assign m_write = m_write_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a done-driven scoreboard monitor.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int W  = 16;
    localparam int LW = 4 * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_read = 1'b0;
    logic [W-1:0]  i_addr = '0;
    logic [W-1:0]  i_rdata;
    logic          i_done;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [W-1:0]  d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_done;
    logic          m_read;
    logic          m_write;
    logic [W-1:0]  m_addr;
    logic [LW-1:0] m_wdata;
    logic [LW-1:0] m_rdata = '0;
    logic          m_done = 1'b0;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_done(m_done), .owner(owner)
    );

    typedef struct {
        logic          side_d;
        logic          chk_data;
        logic [LW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   i_done_cnt = 0;
    int   d_done_cnt = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (i_done) i_done_cnt++;
        if (d_done) d_done_cnt++;
        if (i_done || d_done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {62'b0, d_done, i_done}, '0);
            end else begin
                mon_e = sb.pop_front();
                check("done_side", {62'b0, d_done, i_done}, mon_e.side_d ? 64'd2 : 64'd1);
                if (mon_e.chk_data)
                    check("rdata", mon_e.side_d ? d_rdata : {48'b0, i_rdata}, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; m_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_cmd();
        int n = 0;
        while (!(m_read || m_write) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check("cmd_timeout", 64'd0, 64'd1);
    endtask

    // Memory answers in the lat-th command cycle; the finished requester then drops its request.
    task automatic complete(input int lat, input logic [LW-1:0] line);
        logic was_i, was_d;
        repeat (lat - 1) tick();
        m_rdata = line;
        m_done  = 1'b1;
        @(negedge clk);
        was_i = i_done;
        was_d = d_done;
        @(posedge clk);
        #1;
        m_done  = 1'b0;
        m_rdata = '0;
        if (was_i) i_read = 1'b0;
        if (was_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
    endtask

    logic [W-1:0] wa_addr [3] = '{16'h0021, 16'h0032, 16'h0044};
    logic [W-1:0] wa_line [3] = '{16'h0020, 16'h0030, 16'h0044};
    logic [W-1:0] wa_word [3] = '{16'h2222, 16'h3333, 16'h1111};

    initial begin
        int base_i, base_d, n_d;

        // Reset state
        do_reset();
        check("rst_owner", owner, OWN_NONE);
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_i_done", i_done, 0);
        check("rst_d_done", d_done, 0);

        // I-only fetch, command one cycle after the request, memory answers in 3 cycles
        base_i = i_done_cnt;
        i_read = 1'b1;
        i_addr = 16'h0013;
        tick();
        check("i_owner", owner, OWN_I);
        check("i_m_read", m_read, 1);
        check("i_m_write", m_write, 0);
        check("i_m_addr", m_addr, 16'h0010);
        sb.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 64'hDDDD});
        complete(3, 64'hDDDD_CCCC_BBBB_AAAA);
        check("i_after_m_read", m_read, 0);
        check("i_after_owner", owner, OWN_NONE);
        check("i_done_pulses", i_done_cnt - base_i, 1);

        // Word selection within the returned line
        for (int k = 0; k < 3; k++) begin
            tick();
            i_read = 1'b1;
            i_addr = wa_addr[k];
            tick();
            check("wsel_m_addr", m_addr, wa_line[k]);
            sb.push_back('{side_d: 1'b0, chk_data: 1'b1, data: {48'b0, wa_word[k]}});
            complete(2, 64'h4444_3333_2222_1111);
        end

        // Simultaneous I read and D write: D first, one idle cycle, then I
        do_reset();
        i_read  = 1'b1;
        i_addr  = 16'h0008;
        d_write = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        check("sim_owner_d", owner, OWN_D);
        check("sim_m_write", m_write, 1);
        check("sim_m_read", m_read, 0);
        check("sim_m_addr", m_addr, 16'h0100);
        check("sim_m_wdata", m_wdata, 64'h1234_5678_9ABC_DEF0);
        sb.push_back('{side_d: 1'b1, chk_data: 1'b0, data: '0});
        complete(2, '0);
        check("gap_owner", owner, OWN_NONE);
        check("gap_m_read", m_read, 0);
        check("gap_m_write", m_write, 0);
        tick();
        check("sim_owner_i", owner, OWN_I);
        check("sim_i_m_addr", m_addr, 16'h0008);
        sb.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 64'h5A5A});
        complete(1, 64'h0000_0000_0000_5A5A);

        // Starvation: I held, D re-requests after every completion
        do_reset();
        base_i = i_done_cnt;
        i_read = 1'b1;
        i_addr = 16'h0004;
        d_read = 1'b1;
        d_addr = 16'h0200;
`ifdef MEM_ARB_STARVE_GUARD_EN
        n_d = 4;
`else
        n_d = 6;
`endif
        for (int k = 0; k < n_d; k++) begin
            wait_cmd();
            check("starve_owner_d", owner, OWN_D);
            check("starve_m_read", m_read, 1);
            sb.push_back('{side_d: 1'b1, chk_data: 1'b1, data: 64'(k + 100)});
            complete(2, 64'(k + 100));
            d_read = 1'b1;
        end
        check("starve_no_i_done", i_done_cnt - base_i, 0);
`ifndef MEM_ARB_STARVE_GUARD_EN
        d_read = 1'b0;
`endif
        wait_cmd();
        check("starve_owner_i", owner, OWN_I);
        sb.push_back('{side_d: 1'b0, chk_data: 1'b1, data: 64'h7777});
        complete(2, 64'h0000_0000_0000_7777);
        if (d_read) begin
            wait_cmd();
            check("starve_owner_d_after", owner, OWN_D);
            sb.push_back('{side_d: 1'b1, chk_data: 1'b0, data: '0});
            complete(2, '0);
        end

        // Reset during D_BUSY aborts the write with no done pulse
        do_reset();
        base_d  = d_done_cnt;
        d_write = 1'b1;
        d_addr  = 16'h0080;
        d_wdata = 64'hCAFE_BABE_0000_FFFF;
        tick();
        check("abort_owner_d", owner, OWN_D);
        check("abort_m_write", m_write, 1);
        tick();
        reset   = 1'b1;
        d_write = 1'b0;
        tick();
        reset  = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        check("abort_d_done", d_done, 0);
        check("abort_m_write_low", m_write, 0);
        check("abort_owner", owner, OWN_NONE);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        check("abort_done_pulses", d_done_cnt - base_d, 0);

        // Read+write together is a write; long wait holds the command; stray m_done in IDLE
        do_reset();
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 16'h0040;
        d_wdata = 64'h0BAD_F00D_1111_2222;
        tick();
        check("rw_m_write", m_write, 1);
        check("rw_m_read", m_read, 0);
        check("rw_m_addr", m_addr, 16'h0040);
        check("rw_m_wdata", m_wdata, 64'h0BAD_F00D_1111_2222);
        repeat (6) tick();
        check("rw_held", m_write, 1);
        sb.push_back('{side_d: 1'b1, chk_data: 1'b0, data: '0});
        complete(2, '0);
        base_i = i_done_cnt;
        base_d = d_done_cnt;
        tick();
        m_done = 1'b1;
        @(negedge clk);
        check("stray_i_done", i_done, 0);
        check("stray_d_done", d_done, 0);
        @(posedge clk);
        #1;
        m_done = 1'b0;
        check("stray_owner", owner, OWN_NONE);
        check("stray_pulses", (i_done_cnt - base_i) + (d_done_cnt - base_d), 0);

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
